// File: rtl/pc_btb_fetch.sv
// Fetch-PC generator with a direct-mapped BTB and 2-bit saturating counters.
// EX redirects override the prediction; EX update beats train the BTB.
module pc_btb_fetch #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter int              BTB_ENTRIES = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    output logic [XLEN-1:0] pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target
);

    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    logic [BTB_ENTRIES-1:0] valid_mem;
    logic [TAG_W-1:0]       tag_mem [BTB_ENTRIES];
    logic [XLEN-1:0]        tgt_mem [BTB_ENTRIES];
    logic [1:0]             ctr_mem [BTB_ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;
    logic [XLEN-1:0]  up_tgt;
    logic [XLEN-1:0]  pc_next;

    assign lk_idx = pc[IDX_W+1:2];
    assign lk_tag = pc[XLEN-1:IDX_W+2];
    assign lk_hit = valid_mem[lk_idx] && (tag_mem[lk_idx] == lk_tag);

    assign pred_taken  = lk_hit && ctr_mem[lk_idx][1];
    assign pred_target = lk_hit ? tgt_mem[lk_idx] : '0;

    assign up_idx = upd_pc[IDX_W+1:2];
    assign up_tag = upd_pc[XLEN-1:IDX_W+2];
    assign up_hit = valid_mem[up_idx] && (tag_mem[up_idx] == up_tag);
    assign up_tgt = {upd_target[XLEN-1:2], 2'b00};

    // Redirect beats stall; stall beats the prediction.
    always_comb begin
        pc_next = pc + XLEN'(4);
        if (redirect)
            pc_next = {redirect_pc[XLEN-1:2], 2'b00};
        else if (stall)
            pc_next = pc;
        else if (pred_taken)
            pc_next = pred_target;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pc <= RESET_PC;
        else
            pc <= pc_next;
    end

    // Training ignores stall/redirect; lookups see pre-edge contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_mem <= '0;
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                tag_mem[i] <= '0;
                tgt_mem[i] <= '0;
                ctr_mem[i] <= 2'b00;
            end
        end else if (upd_valid) begin
            if (up_hit) begin
                if (upd_taken) begin
                    if (ctr_mem[up_idx] != 2'b11)
                        ctr_mem[up_idx] <= ctr_mem[up_idx] + 2'd1;
                    tgt_mem[up_idx] <= up_tgt;
                end else if (ctr_mem[up_idx] != 2'b00) begin
                    ctr_mem[up_idx] <= ctr_mem[up_idx] - 2'd1;
                end
            end else if (upd_taken) begin
                valid_mem[up_idx] <= 1'b1;
                tag_mem[up_idx]   <= up_tag;
                tgt_mem[up_idx]   <= up_tgt;
                ctr_mem[up_idx]   <= 2'b10;
            end
        end
    end

endmodule

// File: tb/tb_pc_btb_fetch.sv
// Directed bench for pc_btb_fetch: a cycle table of inputs and expected
// pre-edge outputs, followed by a hand-written asynchronous reset sequence.
module tb_pc_btb_fetch;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_target;

    int checks;
    int errors;

    typedef struct {
        logic        st;
        logic        rd;
        logic [31:0] rp;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utgt;
        logic [31:0] epc;
        logic        ept;
        logic [31:0] etgt;
    } vec_t;

    vec_t vecs[$];

    pc_btb_fetch #(
        .XLEN(32),
        .RESET_PC(32'h0),
        .BTB_ENTRIES(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .stall(stall),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .upd_valid(upd_valid),
        .upd_pc(upd_pc),
        .upd_taken(upd_taken),
        .upd_target(upd_target),
        .pc(pc),
        .pred_taken(pred_taken),
        .pred_target(pred_target)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic add(input logic st, input logic rd, input logic [31:0] rp,
                       input logic uv, input logic [31:0] upc, input logic ut,
                       input logic [31:0] utgt, input logic [31:0] epc,
                       input logic ept, input logic [31:0] etgt);
        vec_t v;
        v.st = st; v.rd = rd; v.rp = rp; v.uv = uv; v.upc = upc; v.ut = ut;
        v.utgt = utgt; v.epc = epc; v.ept = ept; v.etgt = etgt;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [31:0] epc,
                              input logic ept, input logic [31:0] etgt);
        check({tag, " pc"}, pc, epc);
        check({tag, " pred_taken"}, {31'b0, pred_taken}, {31'b0, ept});
        check({tag, " pred_target"}, pred_target, etgt);
    endtask

    task automatic drive(input logic st, input logic rd, input logic [31:0] rp,
                         input logic uv, input logic [31:0] upc, input logic ut,
                         input logic [31:0] utgt);
        stall = st; redirect = rd; redirect_pc = rp;
        upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utgt;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);

        // Each row: inputs held this cycle, and the outputs expected before the next edge.
        //  st rd rp            uv upc       ut utgt          epc           ept etgt
        add(0, 0, 32'h0,        0, 32'h0,  0, 32'h0,        32'h0,        0, 32'h0);
        add(0, 0, 32'h0,        0, 32'h0,  0, 32'h0,        32'h4,        0, 32'h0);
        add(0, 0, 32'h0,        0, 32'h0,  0, 32'h0,        32'h8,        0, 32'h0);
        add(0, 0, 32'h0,        1, 32'h10, 1, 32'h40,       32'hC,        0, 32'h0);
        add(0, 0, 32'h0,        0, 32'h0,  0, 32'h0,        32'h10,       1, 32'h40);
        add(0, 1, 32'h13,       1, 32'h10, 0, 32'h0,        32'h40,       0, 32'h0);
        add(0, 0, 32'h0,        1, 32'h10, 0, 32'h0,        32'h10,       0, 32'h40);
        add(0, 1, 32'h10,       1, 32'h10, 1, 32'h41,       32'h14,       0, 32'h0);
        // same-cycle lookup/update: this cycle still sees ctr=1, target 0x40
        add(0, 0, 32'h0,        1, 32'h10, 1, 32'h44,       32'h10,       0, 32'h40);
        add(0, 1, 32'h10,       0, 32'h0,  0, 32'h0,        32'h14,       0, 32'h0);
        add(0, 0, 32'h0,        0, 32'h0,  0, 32'h0,        32'h10,       1, 32'h44);
        add(1, 1, 32'h203,      0, 32'h0,  0, 32'h0,        32'h44,       0, 32'h0);
        // stalled cycles while 0x50 allocates over 0x10 (same index)
        add(1, 0, 32'h0,        1, 32'h50, 1, 32'h80,       32'h200,      0, 32'h0);
        add(1, 0, 32'h0,        0, 32'h0,  0, 32'h0,        32'h200,      0, 32'h0);
        add(1, 0, 32'h0,        0, 32'h0,  0, 32'h0,        32'h200,      0, 32'h0);
        add(1, 1, 32'h10,       0, 32'h0,  0, 32'h0,        32'h200,      0, 32'h0);
        add(0, 0, 32'h0,        0, 32'h0,  0, 32'h0,        32'h10,       0, 32'h0);
        add(0, 1, 32'h50,       0, 32'h0,  0, 32'h0,        32'h14,       0, 32'h0);
        add(0, 0, 32'h0,        0, 32'h0,  0, 32'h0,        32'h50,       1, 32'h80);
        add(0, 1, 32'h50,       1, 32'h50, 0, 32'h0,        32'h80,       0, 32'h0);
        add(0, 1, 32'hFFFFFFF8, 1, 32'h50, 1, 32'h80,       32'h50,       0, 32'h80);
        add(0, 0, 32'h0,        1, 32'h50, 1, 32'h80,       32'hFFFFFFF8, 0, 32'h0);
        add(0, 0, 32'h0,        1, 32'h50, 1, 32'h80,       32'hFFFFFFFC, 0, 32'h0);
        // counter saturated at 3: one not-taken leaves it at 2, still taken
        add(0, 1, 32'h50,       1, 32'h50, 0, 32'h0,        32'h0,        0, 32'h0);
        add(0, 0, 32'h0,        0, 32'h0,  0, 32'h0,        32'h50,       1, 32'h80);
        add(0, 0, 32'h0,        0, 32'h0,  0, 32'h0,        32'h80,       0, 32'h0);

        #3;
        check_outs("reset", 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].st, vecs[i].rd, vecs[i].rp, vecs[i].uv,
                  vecs[i].upc, vecs[i].ut, vecs[i].utgt);
            #1;
            check_outs($sformatf("row%0d", i), vecs[i].epc, vecs[i].ept, vecs[i].etgt);
            @(negedge clk);
        end

        // Asynchronous reset mid-cycle with the BTB populated and an update in flight.
        drive(0, 0, 0, 1, 32'h10, 1, 32'h40);
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("async_reset", 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        check_outs("held_reset", 32'h0, 1'b0, 32'h0);
        drive(0, 1, 32'h50, 0, 0, 0, 0);
        rst_n = 1'b1;
        #1;
        check_outs("post_reset", 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        drive(0, 1, 32'h10, 0, 0, 0, 0);
        #1;
        check_outs("btb_cleared_50", 32'h50, 1'b0, 32'h0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        check_outs("update_dropped_10", 32'h10, 1'b0, 32'h0);
        @(negedge clk);
        #1;
        check_outs("fallthrough_14", 32'h14, 1'b0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
